// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and helpers for the interrupt priority controller
// Provides the source count, ID width, mask reset value and one-hot helpers.
package irq_pkg;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    localparam logic [NSRC-1:0] MASK_RESET = 8'hFF;

    // One-hot of a source ID.
    function automatic logic [NSRC-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [NSRC-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    // One-hot of the most significant set bit; zero when the vector is empty.
    function automatic logic [NSRC-1:0] msb_onehot(input logic [NSRC-1:0] v);
        logic [NSRC-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/msb_find8.sv
// rtl/msb_find8.sv - combinational highest-set-bit finder for an 8-bit vector
// Ports: vec  - input vector
//        found - any bit of vec set
//        idx   - index of the highest set bit (0 when found=0)
module msb_find8
    import irq_pkg::*;
(
    input  logic [NSRC-1:0] vec,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        found = |vec;
        idx   = '0;
        // Ascending scan so the highest set bit is the last one written.
        for (int i = 0; i < NSRC; i++) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// rtl/irq_priority_ctrl.sv - eight-source prioritised interrupt controller with nesting
// Ports: clk, rst (sync, active-high)
//        en          - global enable; gates irq and ack, edge capture keeps running
//        req         - synchronous request lines, rising edge raises a request
//        mask_wr     - load mask from mask_in
//        mask_in     - new mask value, 1 masks a source
//        ack         - consumer accepts the presented interrupt
//        eoi         - retire the highest-priority in-service source
//        irq, irq_id - registered presented interrupt and its ID
//        pending, in_service, mask - state register views
module irq_priority_ctrl
    import irq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NSRC-1:0] req,
    input  logic            mask_wr,
    input  logic [NSRC-1:0] mask_in,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] mask
);

    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] rise;
    logic            ack_ok;
    logic [NSRC-1:0] ack_bit;
    logic [NSRC-1:0] eoi_bit;
    logic [NSRC-1:0] pending_n;
    logic [NSRC-1:0] mask_n;
    logic [NSRC-1:0] in_service_n;
    logic [NSRC-1:0] cand;
    logic            cand_found;
    logic [IDW-1:0]  cand_top;
    logic            isr_found;
    logic [IDW-1:0]  isr_top;
    logic            irq_n;
    logic [IDW-1:0]  irq_id_n;

    assign rise    = req & ~req_q;
    // An ack only counts against an interrupt that is actually being presented.
    assign ack_ok  = ack & irq & en;
    assign ack_bit = ack_ok ? id_onehot(irq_id) : '0;
    assign eoi_bit = eoi ? msb_onehot(in_service) : '0;

    // Set after clear: a fresh edge on the acked source keeps it pending.
    assign pending_n    = (pending & ~ack_bit) | rise;
    assign mask_n       = mask_wr ? mask_in : mask;
    // eoi retires the old top before the ack adds the new one.
    assign in_service_n = (in_service & ~eoi_bit) | ack_bit;
    assign cand         = pending_n & ~mask_n;

    msb_find8 u_cand_find (
        .vec   (cand),
        .found (cand_found),
        .idx   (cand_top)
    );

    msb_find8 u_isr_find (
        .vec   (in_service_n),
        .found (isr_found),
        .idx   (isr_top)
    );

    // Only a strictly higher ID than anything in service may be presented.
    assign irq_n    = en & cand_found & (~isr_found | (cand_top > isr_top));
    assign irq_id_n = irq_n ? cand_top : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= MASK_RESET;
            irq        <= 1'b0;
            irq_id     <= '0;
        end else begin
            req_q      <= req;
            pending    <= pending_n;
            in_service <= in_service_n;
            mask       <= mask_n;
            irq        <= irq_n;
            irq_id     <= irq_id_n;
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb/tb_irq_priority_ctrl.sv - self-checking bench for irq_priority_ctrl
module tb_irq_priority_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic [7:0] mask;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] m_reqq;
    logic [7:0] m_pend;
    logic [7:0] m_isr;
    logic [7:0] m_mask;
    logic       m_irq;
    logic [2:0] m_id;

    always #5 clk = ~clk;

    irq_priority_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .mask_wr    (mask_wr),
        .mask_in    (mask_in),
        .ack        (ack),
        .eoi        (eoi),
        .irq        (irq),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    function automatic int highest(input logic [7:0] v);
        int h;
        h = -1;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] rise;
        bit         ack_ok;
        int         top;
        int         itop;
        if (rst) begin
            m_reqq = 8'h00;
            m_pend = 8'h00;
            m_isr  = 8'h00;
            m_mask = 8'hFF;
            m_irq  = 1'b0;
            m_id   = 3'd0;
        end else begin
            rise   = req & ~m_reqq;
            m_reqq = req;
            ack_ok = ack && m_irq && en;
            if (ack_ok) m_pend[m_id] = 1'b0;
            m_pend = m_pend | rise;
            if (mask_wr) m_mask = mask_in;
            if (eoi && m_isr != 0) m_isr[highest(m_isr)] = 1'b0;
            if (ack_ok) m_isr[m_id] = 1'b1;
            top   = highest(m_pend & ~m_mask);
            itop  = highest(m_isr);
            m_irq = en && (top >= 0) && (top > itop);
            m_id  = m_irq ? top[2:0] : 3'd0;
        end
    endtask

    // Inputs are applied at the negedge; outputs are compared 1 time unit after posedge.
    task automatic cycle(input logic r, input logic e, input logic [7:0] rq,
                         input logic mw, input logic [7:0] mi,
                         input logic a, input logic eo);
        rst = r; en = e; req = rq; mask_wr = mw; mask_in = mi; ack = a; eoi = eo;
        @(posedge clk);
        model_step();
        #1;
        chk("irq",        {7'd0, irq}, {7'd0, m_irq});
        chk("irq_id",     {5'd0, irq_id}, {5'd0, m_id});
        chk("pending",    pending, m_pend);
        chk("in_service", in_service, m_isr);
        chk("mask",       mask, m_mask);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; mask_wr = 1'b0; mask_in = 8'h00;
        ack = 1'b0; eoi = 1'b0;
        m_reqq = 8'h00; m_pend = 8'h00; m_isr = 8'h00; m_mask = 8'hFF;
        m_irq = 1'b0; m_id = 3'd0;
        @(negedge clk);

        // Reset
        cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
        chk("reset_mask", mask, 8'hFF);
        chk("reset_irq", {7'd0, irq}, 8'h00);

        // Basic request and ack
        cycle(0, 1, 8'h00, 1, 8'h00, 0, 0);
        cycle(0, 1, 8'h08, 0, 8'h00, 0, 0);
        chk("basic_irq_id", {5'd0, irq_id}, 8'h03);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        chk("basic_ack_isr", in_service, 8'h08);
        chk("basic_ack_pend", pending, 8'h00);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);
        chk("basic_eoi_isr", in_service, 8'h00);

        // Priority and nesting
        cycle(0, 1, 8'h24, 0, 8'h00, 0, 0);
        chk("prio_id5", {5'd0, irq_id}, 8'h05);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        chk("prio_no_lower", {7'd0, irq}, 8'h00);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);
        chk("prio_eoi_id2", {irq, 4'd0, irq_id}, 8'h82);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);

        // Preemption and masking
        cycle(0, 1, 8'h02, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        cycle(0, 1, 8'h40, 0, 8'h00, 0, 0);
        chk("preempt_id6", {irq, 4'd0, irq_id}, 8'h86);
        cycle(0, 1, 8'h00, 1, 8'h40, 0, 0);
        chk("mask_irq0", {7'd0, irq}, 8'h00);
        chk("mask_keeps_pend", pending & 8'h40, 8'h40);
        cycle(0, 1, 8'h00, 1, 8'h00, 0, 0);
        chk("unmask_id6", {irq, 4'd0, irq_id}, 8'h86);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);

        // Simultaneous ack and new edge on the same source
        cycle(0, 1, 8'h10, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h10, 0, 8'h00, 1, 0);
        chk("same_bit_pend", pending, 8'h10);
        chk("same_bit_isr", in_service, 8'h10);
        chk("same_bit_irq", {7'd0, irq}, 8'h00);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);

        // ack and eoi together: source 2 in service, 4 presented
        cycle(0, 1, 8'h04, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        cycle(0, 1, 8'h10, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 1);
        chk("ack_eoi_isr", in_service, 8'h10);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 1);

        // Enable gating and stale ack
        cycle(0, 0, 8'h80, 0, 8'h00, 0, 0);
        chk("en0_pend7", pending & 8'h80, 8'h80);
        chk("en0_irq", {7'd0, irq}, 8'h00);
        cycle(0, 0, 8'h00, 0, 8'h00, 1, 0);
        chk("stale_ack_isr", in_service, 8'h00);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);
        chk("stale_ack_pend", pending, 8'h80);
        cycle(0, 1, 8'h00, 0, 8'h00, 0, 0);
        chk("en1_id7", {irq, 4'd0, irq_id}, 8'h87);
        cycle(0, 1, 8'h00, 0, 8'h00, 1, 0);

        // Reset mid-service, with a request held high across release
        cycle(1, 1, 8'h21, 0, 8'h00, 1, 0);
        chk("midrst_mask", mask, 8'hFF);
        chk("midrst_isr", in_service, 8'h00);
        cycle(0, 1, 8'h21, 1, 8'h00, 0, 0);
        chk("held_edge_pend", pending, 8'h21);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) != 0),
                  8'($urandom),
                  ($urandom_range(0, 9) == 0),
                  8'($urandom) & 8'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_priority_ctrl.md
# irq_priority_ctrl

Eight-source interrupt controller that turns asynchronous-free, synchronous request lines into one prioritised interrupt toward a single consumer. It contains edge capture, pending and mask registers, fixed priority selection, and in-service tracking for nested interrupts. Priority follows the team's encoder convention: the highest index wins. The block sits between peripheral request lines and the CPU/sequencer and arbitrates access to that one service path.

## Interface
- NSRC, 8: number of request sources; fixed at 8 for this revision.
- IDW, 3: width of the source ID, log2(NSRC).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable. When 0, irq is forced low and ack is ignored. Edge capture continues.
- req  in  8  request lines, synchronous to clk. A rising edge raises a request.
- mask_wr  in  1  load mask from mask_in this cycle.
- mask_in  in  8  new mask value. Bit=1 masks that source.
- ack  in  1  consumer accepts the presented interrupt. Valid only while irq=1.
- eoi  in  1  end-of-interrupt. Retires the highest-priority in-service source.
- irq  out  1  an interrupt is presented (registered).
- irq_id  out  3  ID of the presented source. Reads 3'b000 whenever irq=0.
- pending  out  8  pending register.
- in_service  out  8  in-service register.
- mask  out  8  mask register.

## Operation
- **Reset values:** pending=0, in_service=0, mask=8'hFF (all masked), req_q=0, irq=0, irq_id=0.
- **Edge capture:** req_q <= req every cycle. rise = req & ~req_q.
  - A line held high across reset release counts as an edge in the first post-reset cycle.
- **Pending next-state:** pending_n = (pending & ~ack_clr) | rise.
  - ack_clr is the one-hot of irq_id, gated by ack & irq & en.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- **Mask:** mask_n = mask_wr ? mask_in : mask.
  - Masking never clears pending; it only blocks presentation.
- **In-service next-state:** apply the two updates in this order:
  1. eoi clears the MSB set in the current in_service. eoi with in_service=0 is a no-op.
  2. A qualified ack sets the bit for irq_id.
  - ack and eoi in the same cycle are legal and use this ordering.
- **Selection:**
  - cand = pending_n & ~mask_n. top = MSB index of cand.
  - isr_top = MSB index of in_service_n; treat it as -1 when in_service_n is empty.
  - irq_n = en & (cand != 0) & (top > isr_top).
  - irq_id_n = irq_n ? top : 0.
- **Next-state rule:** irq and irq_id are registered from next-state values. They therefore never present a source that was acked, masked or retired on the same edge.
- **Nesting:** only a strictly higher ID can preempt an in-service source. Equal or lower IDs wait until eoi.
- **Stale acks:** ack while irq=0 or en=0 is ignored, with no state change.

## Timing
- **Request to irq:** req rises before edge k, so rise is seen at edge k. pending and irq are both set at edge k, giving 1 cycle from req to irq.
- **ack:** ack sampled at edge k updates pending, in_service and irq/irq_id at the same edge k. The next source, if any, is visible right after edge k; there are no dead cycles.
- **eoi:** eoi at edge k can present a waiting lower-priority source immediately after edge k.
- **mask_wr:** takes effect on irq at the same edge.
- **en:** en falling forces irq=0 after the next edge.
- **Reset mid-operation:** rst dominates every input. All registers return to their reset values at that edge, and irq=0 the following cycle.

## Structure
- Shared package/header `irq_pkg`:
  - localparams NSRC=8 and IDW=3.
  - MASK_RESET=8'hFF.
- Sub-module `msb_find8`: purely combinational. 8-bit input → {found, idx[2:0]}, with the highest set bit winning. It is instantiated twice, once for cand and once for in_service_n.
- Everything else is one flat module: edge register, three state registers, output register.

## Test plan
- **Basic request and ack:**
  1. After reset, mask_wr with mask_in=8'h00, en=1.
  2. Pulse req[3] → irq=1, irq_id=3 one cycle later.
  3. ack → pending=0, in_service=8'h08, irq=0.
  4. eoi → in_service=0.
- **Priority and nesting:**
  1. req[2] and req[5] rise together → irq_id=5.
  2. ack → irq_id=2 is not presented (2<5) and irq=0.
  3. eoi → irq=1, irq_id=2 the next cycle.
- **Preemption and masking:**
  1. req[1] is in service. req[6] rises → irq_id=6, since 6>1 preempts.
  2. Set mask bit 6 → irq=0 at the same edge while pending[6] stays 1.
  3. Unmask → irq_id=6 returns.
- **Simultaneous events:**
  1. ack of ID 4 in the same cycle a new req[4] edge arrives → pending[4] remains 1 and in_service[4]=1, so irq=0 (equal priority).
  2. Send ack and eoi together → eoi retires the previous MSB first, then ack sets ID 4.
- **Enable, stale ack, reset:**
  1. With en=0, req[7] edge → pending[7]=1, irq=0. ack is ignored.
  2. en=1 → irq_id=7.
  3. rst asserted mid-service → all outputs at reset values, mask=8'hFF.
